conv_encoder: RTL and testbench
===============================

Name: conv_encoder

Overview:
- Rate-1/2 convolutional encoder with constraint length K=4 (8-state trellis). It is the transmit-side counterpart to the Viterbi decoder chain (branch metrics, ACS, traceback).
- It accepts framed serial data through a valid/ready handshake and emits one 2-bit code symbol per input bit.
- After each frame it appends K-1 = 3 zero tail bits, so the trellis terminates in state 0, which is the state the decoder's traceback starts from.

Parameters:
- FRAME_LEN, 8, number of data bits per frame (1..255); the frame counter is 8 bits.
- G0, 4'b1111, generator polynomial for symbol bit 0, applied to window {s[2],s[1],s[0],din}.
- G1, 4'b1101, generator polynomial for symbol bit 1, applied to the same window.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  block enable; low forces IDLE synchronously.
- start  in  1  one-cycle pulse; begins a frame (honoured in IDLE only).
- in_bit  in  1  data bit.
- in_valid  in  1  in_bit is valid.
- in_ready  out  1  encoder accepts in_bit this cycle.
- out_sym  out  2  code symbol {c1,c0}.
- out_valid  out  1  out_sym is valid.
- out_ready  in  1  downstream accepts out_sym.
- out_last  out  1  marks the final tail symbol of the frame.
- busy  out  1  high in DATA or TAIL.

Behaviour:
- Reset (rst=0, async): state=IDLE, s=3'b000, bit_cnt=0, tail_cnt=0. Outputs reset to out_sym=0, out_valid=0, out_last=0, in_ready=0, busy=0.
- Shift register s[2:0]:
  - Next state = {s[1:0], din}; the newest bit enters at s[0].
  - Window w = {s[2],s[1],s[0],din}.
  - c0 = ^(w & G0), c1 = ^(w & G1).
- slot = !out_valid || out_ready. The output register loads only when slot=1.
- out_sym, out_valid and out_last are registered: the symbol appears one cycle after the bit is accepted.
- If out_valid=1 and out_ready=0, out_sym, out_valid and out_last hold stable and no new bit or tail step occurs.
- When slot=1 and nothing is produced, out_valid goes to 0.
- FSM states:
  - IDLE: in_ready=0. On start=1 (with enable=1): clear s, bit_cnt and tail_cnt, go to DATA. start is ignored in DATA and TAIL.
  - DATA: in_ready = slot (combinational). On accept (in_valid && in_ready): encode in_bit, load the output register, shift s, increment bit_cnt. On the accept that makes bit_cnt == FRAME_LEN, go to TAIL. A cycle with in_valid=0 produces no symbol.
  - TAIL: in_ready=0. Each cycle with slot=1: encode din=0, load the output register, shift s, increment tail_cnt. On the third tail step, set out_last=1 with that symbol and go to IDLE; s is then 3'b000 by construction.
- out_last is high only together with the final tail symbol. It clears when that symbol is consumed or replaced.
- busy = (state != IDLE).
- Frame length: exactly FRAME_LEN + 3 symbols per frame. A new start is accepted in the cycle after the return to IDLE, even while the last symbol is still stalled in the output register.
- enable=0 (synchronous, any state): next edge sets state=IDLE, s=0, counters=0, out_valid=0, out_last=0. A partial frame is discarded; no out_last is produced for it.
- Reset mid-frame: immediate return to the reset values above.
- Simultaneous start and enable=0: enable=0 wins and the block stays IDLE.

Test Plan:
- Impulse, FRAME_LEN=4, bits 1,0,0,0, out_ready=1 -> out_sym sequence 11,01,11,11,00,00,00; out_last only on the 7th symbol; busy falls after it.
- FRAME_LEN=4, bits 1,0,1,1 -> 11,01,00,01 then tail symbols 10,00,11; s=000 at the end.
- Backpressure: same stimulus with out_ready low for 3 cycles mid-frame -> out_sym and out_valid held stable, in_ready=0 during the stall, identical symbol sequence, no loss or duplication.
- Gappy input: in_valid toggling 1,0,0,1,... -> symbols only for accepted bits; the count still totals FRAME_LEN+3.
- Abort: enable=0 after the 2nd data bit -> IDLE next cycle, out_valid=0, no out_last. A following start plus the impulse frame reproduces the impulse sequence (state was cleared).
- Async reset asserted during TAIL -> all outputs 0 immediately, without waiting for a clock edge. After release, start is accepted normally.

Source files
------------

// File: rtl/conv_encoder.sv
// Rate-1/2, K=4 convolutional encoder with framed valid/ready input and a
// three-bit zero tail that returns the trellis to state 0 after every frame.
module conv_encoder #(
  parameter int unsigned FRAME_LEN = 8,
  parameter logic [3:0]  G0        = 4'b1111,
  parameter logic [3:0]  G1        = 4'b1101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       start,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] out_sym,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned TAIL_W   = 2;
  localparam int unsigned TAIL_LEN = 3;

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t              state, state_d;
  logic [2:0]          s, s_d;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_d;
  logic [TAIL_W-1:0]   tail_cnt, tail_cnt_d;
  logic [1:0]          out_sym_d;
  logic                out_valid_d, out_last_d;
  logic                slot, accept;

  // Code symbol {c1,c0} for window {s[2],s[1],s[0],din}.
  function automatic logic [1:0] encode(input logic [2:0] sr, input logic din);
    logic [3:0] w;
    w = {sr, din};
    return {^(w & G1), ^(w & G0)};
  endfunction

  assign slot     = !out_valid || out_ready;
  assign in_ready = enable && (state == DATA) && slot;
  assign accept   = in_ready && in_valid;
  assign busy     = (state != IDLE);

  always_comb begin
    state_d     = state;
    s_d         = s;
    bit_cnt_d   = bit_cnt;
    tail_cnt_d  = tail_cnt;
    out_sym_d   = out_sym;
    out_valid_d = out_valid;
    out_last_d  = out_last;

    if (!enable) begin
      // Synchronous abort: drop any partial frame and the pending symbol.
      state_d     = IDLE;
      s_d         = 3'b000;
      bit_cnt_d   = '0;
      tail_cnt_d  = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      if (slot) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state_d    = DATA;
            s_d        = 3'b000;
            bit_cnt_d  = '0;
            tail_cnt_d = '0;
          end
        end
        DATA: begin
          if (accept) begin
            out_sym_d   = encode(s, in_bit);
            out_valid_d = 1'b1;
            s_d         = {s[1:0], in_bit};
            bit_cnt_d   = bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(FRAME_LEN - 1)) state_d = TAIL;
          end
        end
        TAIL: begin
          if (slot) begin
            out_sym_d   = encode(s, 1'b0);
            out_valid_d = 1'b1;
            s_d         = {s[1:0], 1'b0};
            tail_cnt_d  = tail_cnt + TAIL_W'(1);
            if (tail_cnt == TAIL_W'(TAIL_LEN - 1)) begin
              out_last_d = 1'b1;
              state_d    = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      s         <= 3'b000;
      bit_cnt   <= '0;
      tail_cnt  <= '0;
      out_sym   <= 2'b00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_d;
      s         <= s_d;
      bit_cnt   <= bit_cnt_d;
      tail_cnt  <= tail_cnt_d;
      out_sym   <= out_sym_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder with FRAME_LEN=4; each consumed symbol is
// logged as {last, sym} and compared against hand-computed sequences.
module tb_conv_encoder;

  localparam int unsigned FL   = 4;
  localparam int unsigned NSYM = FL + 3;

  localparam logic [1:0] IMP_E [NSYM] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
  localparam logic [1:0] PAT_E [NSYM] = '{2'b11, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11};
  localparam logic [3:0] IMP_BITS = 4'b0001;  // bits[0] sent first: 1,0,0,0
  localparam logic [3:0] PAT_BITS = 4'b1101;  // 1,0,1,1

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic [1:0] out_sym;
  logic       out_valid;
  logic       out_last;
  logic       busy;

  int checks = 0;
  int passed = 0;

  logic [2:0] q[$];

  conv_encoder #(.FRAME_LEN(FL), .G0(4'b1111), .G1(4'b1101)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start),
    .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
    .out_sym(out_sym), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // Record every symbol that will be consumed at the coming edge.
  always @(negedge clk)
    if (rst && out_valid && out_ready) q.push_back({out_last, out_sym});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, output logic ok);
    logic acc;
    ok = 1'b0;
    in_bit = b;
    in_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) $display("FAIL send_bit: in_ready never seen, got 0 required 1");
    else passed++;
  endtask

  task automatic send_frame(input logic [3:0] bits, input int gap);
    logic ok;
    for (int i = 0; i < int'(FL); i++) begin
      if (i > 0) repeat (gap) tick();
      send_bit(bits[i], ok);
    end
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while ((q.size() < NSYM || busy) && cyc < 200) begin
      tick();
      cyc++;
    end
    tick();
    checks++;
    if (q.size() != NSYM || busy)
      $display("FAIL %s_count: got %0d symbols busy=%0b, required %0d busy=0", name, q.size(), busy, NSYM);
    else passed++;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    repeat (2) @(negedge clk);
    checks += 5;
    if (out_sym !== 2'b00) $display("FAIL reset_out_sym: got %0b required 00", out_sym); else passed++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b required 0", out_valid); else passed++;
    if (out_last !== 1'b0) $display("FAIL reset_out_last: got %0b required 0", out_last); else passed++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b required 0", in_ready); else passed++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %0b required 0", busy); else passed++;
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
  endtask

  task automatic test_impulse();
    logic [2:0] exp;
    do_start();
    send_frame(IMP_BITS, 0);
    wait_done("impulse");
    for (int i = 0; i < int'(NSYM); i++) begin
      exp = {(i == int'(NSYM) - 1), IMP_E[i]};
      checks++;
      if (i >= q.size() || q[i] !== exp)
        $display("FAIL impulse_sym%0d: got %0b required %0b", i, (i < q.size()) ? q[i] : 3'bxxx, exp);
      else passed++;
    end
  endtask

  task automatic test_pattern();
    logic [2:0] exp;
    do_start();
    send_frame(PAT_BITS, 0);
    wait_done("pattern");
    for (int i = 0; i < int'(NSYM); i++) begin
      exp = {(i == int'(NSYM) - 1), PAT_E[i]};
      checks++;
      if (i >= q.size() || q[i] !== exp)
        $display("FAIL pattern_sym%0d: got %0b required %0b", i, (i < q.size()) ? q[i] : 3'bxxx, exp);
      else passed++;
    end
    checks++;
    if (dut.s !== 3'b000) $display("FAIL pattern_final_state: got %0b required 000", dut.s);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [2:0] exp;
    do_start();
    fork
      send_frame(PAT_BITS, 0);
      begin
        int cyc = 0;
        while (q.size() < 2 && cyc < 100) begin
          tick();
          cyc++;
        end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks += 3;
          if (out_valid !== 1'b1) $display("FAIL stall_valid%0d: got %0b required 1", k, out_valid); else passed++;
          if (out_sym !== PAT_E[2]) $display("FAIL stall_sym%0d: got %0b required %0b", k, out_sym, PAT_E[2]); else passed++;
          if (in_ready !== 1'b0) $display("FAIL stall_in_ready%0d: got %0b required 0", k, in_ready); else passed++;
        end
        tick();
        out_ready = 1'b1;
      end
    join
    wait_done("backpressure");
    for (int i = 0; i < int'(NSYM); i++) begin
      exp = {(i == int'(NSYM) - 1), PAT_E[i]};
      checks++;
      if (i >= q.size() || q[i] !== exp)
        $display("FAIL backpressure_sym%0d: got %0b required %0b", i, (i < q.size()) ? q[i] : 3'bxxx, exp);
      else passed++;
    end
  endtask

  task automatic test_gappy();
    logic [2:0] exp;
    do_start();
    send_frame(PAT_BITS, 2);
    wait_done("gappy");
    for (int i = 0; i < int'(NSYM); i++) begin
      exp = {(i == int'(NSYM) - 1), PAT_E[i]};
      checks++;
      if (i >= q.size() || q[i] !== exp)
        $display("FAIL gappy_sym%0d: got %0b required %0b", i, (i < q.size()) ? q[i] : 3'bxxx, exp);
      else passed++;
    end
  endtask

  task automatic test_abort();
    logic ok;
    logic any_last;
    do_start();
    send_bit(1'b1, ok);
    send_bit(1'b1, ok);
    enable = 1'b0;
    tick();
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b0) $display("FAIL abort_busy: got %0b required 0", busy); else passed++;
    if (out_valid !== 1'b0) $display("FAIL abort_out_valid: got %0b required 0", out_valid); else passed++;
    if (out_last !== 1'b0) $display("FAIL abort_out_last: got %0b required 0", out_last); else passed++;
    // start while disabled must be ignored
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL abort_start_ignored: got busy=%0b required 0", busy); else passed++;
    any_last = 1'b0;
    foreach (q[i]) any_last |= q[i][2];
    checks++;
    if (q.size() != 2 || any_last)
      $display("FAIL abort_partial: got %0d symbols last=%0b, required 2 last=0", q.size(), any_last);
    else passed++;
    tick();
    test_impulse();
  endtask

  task automatic test_reset_tail();
    do_start();
    send_frame(PAT_BITS, 0);
    @(negedge clk);
    checks++;
    if (!(busy && out_valid)) $display("FAIL pre_reset_tail: got busy=%0b valid=%0b required 1 1", busy, out_valid);
    else passed++;
    #2 rst = 1'b0;
    #1;
    checks += 5;
    if (out_sym !== 2'b00) $display("FAIL async_out_sym: got %0b required 00", out_sym); else passed++;
    if (out_valid !== 1'b0) $display("FAIL async_out_valid: got %0b required 0", out_valid); else passed++;
    if (out_last !== 1'b0) $display("FAIL async_out_last: got %0b required 0", out_last); else passed++;
    if (in_ready !== 1'b0) $display("FAIL async_in_ready: got %0b required 0", in_ready); else passed++;
    if (busy !== 1'b0) $display("FAIL async_busy: got %0b required 0", busy); else passed++;
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    test_impulse();
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_pattern();
    test_backpressure();
    test_gappy();
    test_abort();
    test_reset_tail();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

endmodule
